// File: rtl/datapath_seq.sv
// Command sequencer that walks the lab datapath through read, execute and writeback.
// Define DATAPATH_SEQ_B2B_EN to accept the next command while in DONE (back-to-back issue).
module datapath_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [2:0]       cmd_rd,
  input  logic [2:0]       cmd_rn,
  input  logic [2:0]       cmd_rm,
  input  logic [1:0]       cmd_shift,
  input  logic [1:0]       cmd_alu,
  input  logic [15:0]      cmd_imm,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic             vsel,
  output logic             loada,
  output logic             loadb,
  output logic             asel,
  output logic             bsel,
  output logic             loadc,
  output logic             loads,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [15:0]      datapath_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [1:0] K_MOVI = 2'b00;
  localparam logic [1:0] K_MOV  = 2'b01;
  localparam logic [1:0] K_ALU  = 2'b10;
  localparam logic [1:0] K_CMP  = 2'b11;

`ifdef DATAPATH_SEQ_B2B_EN
  localparam logic DONE_READY = 1'b1;
`else
  localparam logic DONE_READY = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  rd;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  shift;
    logic [1:0]  alu;
    logic [15:0] imm;
  } cmd_t;

  typedef struct packed {
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic        loadc;
    logic        loads;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic        ready;
  } outs_t;

  state_t state, nxt_state;
  cmd_t   cmd, nxt_cmd;
  outs_t  o;
  logic   accept;

  // Output image of a (state, latched command) pair; registered so outputs never see cmd_* directly.
  function automatic outs_t decode(input state_t s, input cmd_t c);
    outs_t r;
    r      = '0;
    r.din  = c.imm;
    r.busy = (s != S_IDLE);
    case (s)
      S_IDLE: r.ready = 1'b1;
      S_LOAD_A: begin
        r.readnum = c.rn;
        r.loada   = 1'b1;
      end
      S_LOAD_B: begin
        r.readnum = c.rm;
        r.loadb   = 1'b1;
      end
      S_EXEC: begin
        r.shift = c.shift;
        r.bsel  = 1'b0;
        case (c.kind)
          K_MOV: begin
            r.asel  = 1'b1;
            r.aluop = 2'b00;
            r.loadc = 1'b1;
          end
          K_CMP: begin
            r.aluop = c.alu;
            r.loads = 1'b1;
          end
          default: begin
            r.aluop = c.alu;
            r.loadc = 1'b1;
            r.loads = 1'b1;
          end
        endcase
      end
      S_WRITE: begin
        r.writenum = c.rd;
        r.write    = 1'b1;
        r.vsel     = (c.kind == K_MOVI);
      end
      S_DONE: begin
        r.done  = 1'b1;
        r.ready = DONE_READY;
      end
      default: r.ready = 1'b0;
    endcase
    return r;
  endfunction

  function automatic state_t first_state(input logic [1:0] k);
    case (k)
      K_MOVI:  return S_WRITE;
      K_MOV:   return S_LOAD_B;
      default: return S_LOAD_A;
    endcase
  endfunction

  assign accept = cmd_valid && o.ready;

  always_comb begin
    nxt_cmd   = cmd;
    nxt_state = S_IDLE;
    if (accept) begin
      nxt_cmd = '{kind: cmd_kind, rd: cmd_rd, rn: cmd_rn, rm: cmd_rm,
                  shift: cmd_shift, alu: cmd_alu, imm: cmd_imm};
    end
    case (state)
      S_IDLE:   nxt_state = accept ? first_state(cmd_kind) : S_IDLE;
      S_LOAD_A: nxt_state = S_LOAD_B;
      S_LOAD_B: nxt_state = S_EXEC;
      S_EXEC:   nxt_state = (cmd.kind == K_CMP) ? S_DONE : S_WRITE;
      S_WRITE:  nxt_state = S_DONE;
      S_DONE:   nxt_state = accept ? first_state(cmd_kind) : S_IDLE;
      default:  nxt_state = S_IDLE;
    endcase
  end

  // State, latched command, output image and completion counter all advance together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cmd      <= '0;
      o        <= decode(S_IDLE, '0);
      ops_done <= '0;
    end else begin
      state <= nxt_state;
      cmd   <= nxt_cmd;
      o     <= decode(nxt_state, nxt_cmd);
      if (o.done) ops_done <= ops_done + CNT_W'(1);
    end
  end

  assign cmd_ready   = o.ready;
  assign readnum     = o.readnum;
  assign writenum    = o.writenum;
  assign write       = o.write;
  assign vsel        = o.vsel;
  assign loada       = o.loada;
  assign loadb       = o.loadb;
  assign asel        = o.asel;
  assign bsel        = o.bsel;
  assign loadc       = o.loadc;
  assign loads       = o.loads;
  assign shift       = o.shift;
  assign ALUop       = o.aluop;
  assign datapath_in = o.din;
  assign busy        = o.busy;
  assign done        = o.done;

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: queue-based command model checked every cycle, plus directed literal checks.
module tb_datapath_seq;
  localparam int CW = 4;
`ifdef DATAPATH_SEQ_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_kind = '0;
  logic [2:0]    cmd_rd = '0, cmd_rn = '0, cmd_rm = '0;
  logic [1:0]    cmd_shift = '0, cmd_alu = '0;
  logic [15:0]   cmd_imm = '0;
  logic [2:0]    readnum, writenum;
  logic          write, vsel, loada, loadb, asel, bsel, loadc, loads;
  logic [1:0]    shift, ALUop;
  logic [15:0]   datapath_in;
  logic          busy, done;
  logic [CW-1:0] ops_done;

  datapath_seq #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_shift(cmd_shift), .cmd_alu(cmd_alu), .cmd_imm(cmd_imm),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc),
    .loads(loads), .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in),
    .busy(busy), .done(done), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  rdn;
    logic [2:0]  wrn;
    logic        wr, vs, la, lb, as, bs, lc, ls;
    logic [1:0]  sh, op;
    logic [15:0] din;
    logic        bz, dn, rdy;
  } vec_t;

  int checks = 0;
  int passes = 0;

  vec_t          q[$];
  logic [15:0]   last_imm = '0;
  logic [CW-1:0] mcnt = '0;
  vec_t          mexp, cexp, cact;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic vec_t idle_vec();
    vec_t v = '0;
    v.din = last_imm;
    v.rdy = 1'b1;
    return v;
  endfunction

  // Expected per-cycle outputs for one command, derived from the kind's step list.
  task automatic push_seq(input logic [1:0] k, input logic [2:0] rd, input logic [2:0] rn,
                          input logic [2:0] rm, input logic [1:0] sh, input logic [1:0] alu,
                          input logic [15:0] imm);
    int steps[$];
    case (k)
      2'b00:   steps = '{3, 4};
      2'b01:   steps = '{1, 2, 3, 4};
      2'b10:   steps = '{0, 1, 2, 3, 4};
      default: steps = '{0, 1, 2, 4};
    endcase
    foreach (steps[i]) begin
      vec_t v = '0;
      v.din = imm;
      v.bz  = 1'b1;
      case (steps[i])
        0: begin v.rdn = rn; v.la = 1'b1; end
        1: begin v.rdn = rm; v.lb = 1'b1; end
        2: begin
          v.sh = sh;
          v.as = (k == 2'b01);
          v.op = (k == 2'b01) ? 2'b00 : alu;
          v.lc = (k != 2'b11);
          v.ls = (k != 2'b01);
        end
        3: begin v.wrn = rd; v.wr = 1'b1; v.vs = (k == 2'b00); end
        default: begin v.dn = 1'b1; v.rdy = B2B; end
      endcase
      q.push_back(v);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      mcnt     = '0;
      last_imm = '0;
    end else begin
      mexp = (q.size() != 0) ? q[0] : idle_vec();
      if (mexp.dn) mcnt = mcnt + 1'b1;
      if (q.size() != 0) void'(q.pop_front());
      if (cmd_valid && mexp.rdy) begin
        last_imm = cmd_imm;
        push_seq(cmd_kind, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_alu, cmd_imm);
      end
    end
  end

  always @(negedge clk) begin
    cexp = (q.size() != 0) ? q[0] : idle_vec();
    cact = {readnum, writenum, write, vsel, loada, loadb, asel, bsel, loadc, loads,
            shift, ALUop, datapath_in, busy, done, cmd_ready};
    chk("cycle_outputs", cact, cexp);
    chk("cycle_ops_done", ops_done, mcnt);
  end

  task automatic send(input logic [1:0] k, input logic [2:0] rd, input logic [2:0] rn,
                      input logic [2:0] rm, input logic [1:0] sh, input logic [1:0] alu,
                      input logic [15:0] imm);
    int n = 0;
    cmd_valid = 1'b1; cmd_kind = k; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
    cmd_shift = sh; cmd_alu = alu; cmd_imm = imm;
    while (!cmd_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int ndone, last, ndone_rst;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ops", ops_done, 0);
    chk("rst_din", datapath_in, 0);
    reset = 1'b0;
    @(negedge clk);

    // MOVI rd=3 imm=0042
    send(2'b00, 3'd3, 3'd0, 3'd0, 2'b00, 2'b00, 16'h0042);
    chk("movi_write", write, 1);
    chk("movi_vsel", vsel, 1);
    chk("movi_writenum", writenum, 3);
    chk("movi_din", datapath_in, 16'h0042);
    @(negedge clk);
    chk("movi_done", done, 1);
    @(negedge clk);
    chk("movi_ops", ops_done, 1);
    chk("movi_din_hold", datapath_in, 16'h0042);

    // ALU add rn=1 rm=2 shift=01 rd=5
    send(2'b10, 3'd5, 3'd1, 3'd2, 2'b01, 2'b00, 16'h1234);
    chk("alu_c1", {readnum, loada, loadb}, {3'd1, 1'b1, 1'b0});
    @(negedge clk);
    chk("alu_c2", {readnum, loada, loadb}, {3'd2, 1'b0, 1'b1});
    @(negedge clk);
    chk("alu_c3", {loadc, loads, shift, ALUop, asel, bsel}, {1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0});
    @(negedge clk);
    chk("alu_c4", {write, writenum, vsel}, {1'b1, 3'd5, 1'b0});
    @(negedge clk);
    chk("alu_done", done, 1);
    @(negedge clk);

    // CMP alu=01
    send(2'b11, 3'd7, 3'd4, 3'd6, 2'b10, 2'b01, 16'h00ff);
    @(negedge clk);
    @(negedge clk);
    chk("cmp_exec", {loads, loadc, write, ALUop}, {1'b1, 1'b0, 1'b0, 2'b01});
    @(negedge clk);
    chk("cmp_done", {done, write}, {1'b1, 1'b0});
    @(negedge clk);

    // MOV rm=4 shift=11
    send(2'b01, 3'd2, 3'd0, 3'd4, 2'b11, 2'b10, 16'h0000);
    chk("mov_c1", {readnum, loadb, loada}, {3'd4, 1'b1, 1'b0});
    @(negedge clk);
    chk("mov_exec", {asel, ALUop, loadc, loads}, {1'b1, 2'b00, 1'b1, 1'b0});
    wait_idle();

    // Hold-off: second command presented while busy
    send(2'b10, 3'd1, 3'd3, 3'd4, 2'b00, 2'b10, 16'h0101);
    send(2'b00, 3'd6, 3'd0, 3'd0, 2'b00, 2'b00, 16'hBEEF);
    chk("holdoff_write", {write, writenum, datapath_in}, {1'b1, 3'd6, 16'hBEEF});
    wait_idle();
    chk("holdoff_ops", ops_done, 6);

    // Reset asynchronously during EXEC of an ALU command
    send(2'b10, 3'd1, 3'd2, 3'd3, 2'b00, 2'b00, 16'h5555);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_exec", loadc, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_strobes", {write, vsel, loada, loadb, asel, bsel, loadc, loads, done}, 9'd0);
    chk("mid_rst_addr", {readnum, writenum, shift, ALUop, datapath_in}, 26'd0);
    chk("mid_rst_ctl", {busy, cmd_ready}, 2'b01);
    chk("mid_rst_ops", ops_done, 0);
    #1 reset = 1'b0;
    ndone_rst = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone_rst++;
    end
    chk("rst_no_done", ndone_rst, 0);

    // Counter wrap: 16 MOVIs with cmd_valid held high
    cmd_kind = 2'b00; cmd_rd = 3'd1; cmd_imm = 16'h0A5A; cmd_valid = 1'b1;
    ndone = 0;
    last  = -1;
    for (int c = 0; c < 100 && ndone < 16; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (last >= 0) chk("done_gap", c - last, B2B ? 2 : 3);
        last = c;
        if (ndone == 16) begin
          chk("wrap_pre", ops_done, 15);
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    chk("wrap_count", ndone, 16);
    @(negedge clk);
    chk("wrap_ops", ops_done, 0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Automatic initiator for the lab datapath.
- Accepts one command per valid/ready handshake and drives the datapath control strobes through the register-read, execute and writeback stages over several clk cycles.
- Replaces hand-toggled switch control. Sits between a command source (future instruction decoder or test FSM) and the datapath.
- Counts completed commands.

Parameters:
- CNT_W, 16, width of completed-command counter ops_done.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_kind  in  2  00 MOVI, 01 MOV, 10 ALU, 11 CMP
- cmd_rd  in  3  destination register
- cmd_rn  in  3  A-operand register
- cmd_rm  in  3  B-operand register
- cmd_shift  in  2  shifter control for B operand
- cmd_alu  in  2  ALUop (00 add, 01 sub, 10 and, 11 not-B)
- cmd_imm  in  16  immediate for MOVI
- readnum, writenum  out  3 each  register file addresses
- write, vsel, loada, loadb, asel, bsel, loadc, loads  out  1 each  datapath strobes/selects
- shift, ALUop  out  2 each  datapath execute controls
- datapath_in  out  16  immediate to datapath
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, command complete
- ops_done  out  CNT_W  completed-command count

Behaviour:
- Datapath contract:
  - vsel=1 writes datapath_in; vsel=0 writes C.
  - asel=1 forces A=0; bsel=0 selects shifted B.
- Acceptance:
  - Command accepted on a rising clk when cmd_valid && cmd_ready.
  - All cmd_* fields are latched into an internal command register at that edge.
  - Outputs depend only on the state and the latched register; there is no combinational path from cmd_* to outputs.
  - cmd_ready=1 only in IDLE (see Optional Feature).
- States: IDLE, LOAD_A, LOAD_B, EXEC, WRITE, DONE.
- Sequences after acceptance:
  - MOVI: WRITE, DONE.
  - MOV: LOAD_B, EXEC, WRITE, DONE.
  - ALU: LOAD_A, LOAD_B, EXEC, WRITE, DONE.
  - CMP: LOAD_A, LOAD_B, EXEC, DONE.
  - DONE → IDLE.
  - Any unreachable encoding → IDLE.
- Per-state outputs (all unlisted strobes are 0):
  - LOAD_A: readnum=rn, loada=1.
  - LOAD_B: readnum=rm, loadb=1.
  - EXEC: shift=cmd_shift, bsel=0.
    - MOV: asel=1, ALUop=00, loadc=1.
    - ALU: asel=0, ALUop=cmd_alu, loadc=1, loads=1.
    - CMP: asel=0, ALUop=cmd_alu, loadc=0, loads=1.
  - WRITE: writenum=rd, write=1.
    - MOVI: vsel=1, datapath_in=cmd_imm.
    - Otherwise: vsel=0.
  - DONE: done=1.
  - datapath_in holds the latched cmd_imm in every state; it is 0 after reset.
- Latency (accept edge to done high):
  - MOVI: 2 cycles.
  - MOV: 4 cycles.
  - ALU: 5 cycles.
  - CMP: 4 cycles.
- ops_done increments by 1 on every clk edge where done=1; wraps from all-ones to 0.
- cmd_valid deasserting mid-command has no effect; the command runs to completion.
- Reset (async, any time including mid-command):
  - state=IDLE, latched command=0, ops_done=0.
  - Hence all strobes=0, readnum/writenum/shift/ALUop=0, datapath_in=0, done=0, busy=0, cmd_ready=1.
  - An interrupted command is discarded and never reports done.

Optional Feature:
- Macro: DATAPATH_SEQ_B2B_EN.
- Defined:
  - cmd_ready=1 also in DONE.
  - A command accepted in DONE goes directly to its first state, skipping IDLE.
  - done still pulses for the finishing command and ops_done still increments.
  - Back-to-back MOVI throughput is 1 command per 2 cycles.
- Undefined:
  - cmd_ready=1 only in IDLE.
  - DONE always → IDLE; minimum spacing is sequence length + 1 cycles.

Test Plan:
- Reset mid-run: reset pulsed during EXEC of an ALU command, asynchronously between edges → all outputs zero immediately, cmd_ready=1, ops_done=0, no done pulse.
- MOVI: cmd_kind=00, rd=3, imm=16'h0042 → next cycle write=1, vsel=1, writenum=3, datapath_in=0042; the cycle after, done=1; ops_done=1.
- ALU add: rn=1, rm=2, shift=01, alu=00, rd=5 → exact order LOAD_A(readnum=1, loada), LOAD_B(readnum=2, loadb), EXEC(loadc, loads, shift=01, ALUop=00), WRITE(writenum=5, vsel=0), DONE; done 5 cycles after accept.
- CMP: alu=01 → EXEC has loads=1 and loadc=0; write never asserted; done 4 cycles after accept.
- Handshake hold-off: cmd_valid held high with new fields while busy → no field change visible on outputs; second command accepted only when cmd_ready=1; ops_done=2 after both.
- Counter wrap: CNT_W=4; run 16 MOVIs → ops_done returns to 0. With DATAPATH_SEQ_B2B_EN, done pulses on every second cycle.
